// File: rtl/apb_cfg_pkg.sv
// Shared definitions for the APB configuration master: FSM state encoding
// and the default bus/timeout dimensions used by the interface and modules.
package apb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEFAULT_ADDRESS_BUS_WIDTH = 16;
  localparam int DEFAULT_DATA_BUS_WIDTH    = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES    = 255;
  localparam int DEFAULT_TIMEOUT_WIDTH     = 8;

endpackage

// File: rtl/apb_cfg_master_if.sv
// Command/response handshake plus APB bus signals of one configuration master.
// The master modport is the requester's view; the slave modport is the view
// of everything around it (system controller and the APB register bank).
interface apb_cfg_master_if
  import apb_cfg_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
  parameter int DATA_BUS_WIDTH    = DEFAULT_DATA_BUS_WIDTH
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [ADDRESS_BUS_WIDTH-1:0] cmd_addr;
  logic [DATA_BUS_WIDTH-1:0]    cmd_wdata;

  logic                         rsp_valid;
  logic [DATA_BUS_WIDTH-1:0]    rsp_rdata;
  logic                         rsp_err;

  logic                         psel;
  logic                         penable;
  logic                         pwrite;
  logic [ADDRESS_BUS_WIDTH-1:0] paddr;
  logic [DATA_BUS_WIDTH-1:0]    pwdata;
  logic                         pready;
  logic [DATA_BUS_WIDTH-1:0]    prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. 'expired' flags the cycle in which one more
// not-ready edge would bring the count up to LIMIT, so the owner can abort
// on that same edge.
module apb_wait_timer
  import apb_cfg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_TIMEOUT_WIDTH,
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic pclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Count enabled cycles, clear on request, and stick at all-ones instead of wrapping
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_cfg_master.sv
// APB requester for the configuration-register bus. Takes one read/write
// command at a time, runs SETUP/ACCESS, and returns data or a timeout error
// on a single-cycle response strobe.
module apb_cfg_master
  import apb_cfg_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
  parameter int DATA_BUS_WIDTH    = DEFAULT_DATA_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH     = DEFAULT_TIMEOUT_WIDTH
) (
  input logic              pclk,
  input logic              reset,
  apb_cfg_master_if.master bus
);

  apb_state_e state, next_state;

  logic                         pready_ok;
  logic                         accept;
  logic                         complete;
  logic                         abort;
  logic                         timer_clear;
  logic                         timer_enable;
  logic                         timer_expired;
  logic                         cmd_ready_c;
  logic                         psel_c;
  logic                         penable_c;

  logic                         pwrite_q;
  logic [ADDRESS_BUS_WIDTH-1:0] paddr_q;
  logic [DATA_BUS_WIDTH-1:0]    pwdata_q;
  logic                         rsp_valid_q;
  logic                         rsp_err_q;
  logic [DATA_BUS_WIDTH-1:0]    rsp_rdata_q;

  // A floating or unknown pready line must never be taken as ready
  assign pready_ok = (bus.pready === 1'b1);

  apb_wait_timer #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk    (pclk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State register; reset drops straight back to IDLE so psel/penable fall without a clock
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus-phase decode; success is checked before timeout so ready wins at the limit
  always_comb begin
    next_state   = state;
    cmd_ready_c  = 1'b0;
    psel_c       = 1'b0;
    penable_c    = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        psel_c      = 1'b1;
        timer_clear = 1'b1;
        next_state  = ACCESS;
      end
      ACCESS: begin
        psel_c       = 1'b1;
        penable_c    = 1'b1;
        timer_enable = !pready_ok;
        if (pready_ok) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (timer_expired) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address, direction and write data are captured once per command and held until the next one
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= bus.cmd_write;
      paddr_q  <= bus.cmd_addr;
      pwdata_q <= bus.cmd_wdata;
    end
  end

  // Response strobe lasts one cycle; data is only meaningful for successful reads
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= complete || abort;
      if (complete) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
      end else if (abort) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.psel      = psel_c;
  assign bus.penable   = penable_c;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench for apb_cfg_master. A reactive APB slave model lives
// inside do_txn; expected latency, error and read data come from the
// transaction-level rules (wait states vs. timeout limit).
module tb_apb_cfg_master;
  import apb_cfg_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int TW = 8;

  logic pclk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int failures = 0;

  apb_cfg_master_if #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();

  apb_cfg_master #(
    .ADDRESS_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH    (DW),
    .TIMEOUT_CYCLES    (TO),
    .TIMEOUT_WIDTH     (TW)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 pclk = ~pclk;

  // One complete transaction with a slave that raises pready in the (waits+1)-th ACCESS cycle
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdval, input string name);
    int exp_lat;
    logic exp_err;
    logic [DW-1:0] exp_rdata;
    logic exp_en;
    int access_seen;
    int bad_cyc;
    bit done;
    exp_err   = (waits >= TO);
    exp_lat   = exp_err ? TO + 2 : waits + 3;
    exp_rdata = (wr || exp_err) ? '0 : rdval;
    access_seen = 0;
    bad_cyc = -1;
    done = 0;
    @(negedge pclk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s cmd_ready_idle: got %b expected 1", name, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.pready    = 1'b0;
    for (int cyc = 1; cyc <= TO + 8 && !done; cyc++) begin
      @(negedge pclk);
      if (cyc == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
      end
      if (bus.rsp_valid === 1'b1) begin
        done = 1;
        checks++;
        if (cyc != exp_lat) begin
          failures++;
          $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
        end
        checks++;
        if (bus.rsp_err !== exp_err) begin
          failures++;
          $display("[TB] FAIL %s rsp_err: got %b expected %b", name, bus.rsp_err, exp_err);
        end
        checks++;
        if (bus.rsp_rdata !== exp_rdata) begin
          failures++;
          $display("[TB] FAIL %s rsp_rdata: got %h expected %h", name, bus.rsp_rdata, exp_rdata);
        end
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.cmd_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s end_state: got psel=%b penable=%b cmd_ready=%b expected 0 0 1",
                   name, bus.psel, bus.penable, bus.cmd_ready);
        end
      end else begin
        exp_en = (cyc >= 2);
        if (bad_cyc < 0 && (bus.psel !== 1'b1 || bus.penable !== exp_en || bus.paddr !== addr ||
                            bus.pwdata !== wdata || bus.pwrite !== wr))
          bad_cyc = cyc;
        if (bus.penable === 1'b1) begin
          access_seen++;
          bus.pready = (access_seen == waits + 1);
          bus.prdata = bus.pready ? rdval : DW'($urandom);
        end else begin
          bus.pready = 1'($urandom);
          bus.prdata = DW'($urandom);
        end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s rsp_timeout: got no rsp_valid expected one within %0d cycles", name, TO + 8);
    end
    checks++;
    if (bad_cyc >= 0) begin
      failures++;
      $display("[TB] FAIL %s bus_phase: got wrong psel/penable/paddr/pwdata/pwrite at cycle %0d expected SETUP then ACCESS with addr=%h wdata=%h",
               name, bad_cyc, addr, wdata);
    end
    bus.pready = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    reset = 1'b0;
    #12;
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0 ||
        bus.paddr !== '0 || bus.pwdata !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bus: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h expected all 0",
               bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin
      failures++;
      $display("[TB] FAIL reset_rsp: got valid=%b err=%b rdata=%h expected all 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    do_txn(1'b1, 16'h0004, 32'h0000_0003, 0, 32'h0BAD_F00D, "write_zero_wait");
  endtask

  task automatic test_read_wait_states();
    do_txn(1'b0, 16'h0008, 32'h0000_0000, 2, 32'hDEAD_BEEF, "read_two_waits");
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 16'h000C, 32'h1234_5678, 1000, 32'hCAFE_CAFE, "read_timeout");
    do_txn(1'b1, 16'h00AC, 32'h8765_4321, TO, 32'hCAFE_CAFE, "write_timeout");
  endtask

  task automatic test_limit_edge();
    do_txn(1'b0, 16'h0014, 32'h0, TO - 1, 32'hA5A5_5A5A, "read_limit_edge");
  endtask

  task automatic test_back_to_back();
    int rsp_cnt;
    int rise_cnt;
    int first_rsp_cyc;
    int second_setup_cyc;
    logic prev_psel;
    logic [AW-1:0] second_paddr;
    bit addr_ok;
    rsp_cnt = 0;
    rise_cnt = 0;
    first_rsp_cyc = -1;
    second_setup_cyc = -1;
    prev_psel = 1'b0;
    second_paddr = '0;
    addr_ok = 1;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h0010;
    bus.cmd_wdata = 32'h1111_0000;
    bus.pready    = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge pclk);
      if (bus.psel === 1'b1 && prev_psel !== 1'b1) begin
        rise_cnt++;
        if (rise_cnt == 2) begin
          second_setup_cyc = cyc;
          second_paddr = bus.paddr;
          bus.cmd_valid = 1'b0;
        end
      end
      prev_psel = bus.psel;
      if (rsp_cnt == 0 && bus.psel === 1'b1 && bus.paddr !== 16'h0010) addr_ok = 0;
      if (bus.rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_cnt == 1) begin
          first_rsp_cyc = cyc;
          bus.cmd_addr = 16'h0020;
        end
      end else if (rsp_cnt == 0) begin
        bus.cmd_addr = (bus.cmd_addr == 16'h0010) ? 16'h0020 : 16'h0010;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.pready = 1'b0;
    checks++;
    if (!addr_ok) begin
      failures++;
      $display("[TB] FAIL b2b_paddr_stable: got paddr change during first transfer expected 0010 throughout");
    end
    checks++;
    if (rsp_cnt != 2 || rise_cnt != 2) begin
      failures++;
      $display("[TB] FAIL b2b_count: got rsp=%0d setups=%0d expected 2 2", rsp_cnt, rise_cnt);
    end
    checks++;
    if (second_setup_cyc != first_rsp_cyc + 1 || first_rsp_cyc != 3) begin
      failures++;
      $display("[TB] FAIL b2b_timing: got rsp1 at %0d setup2 at %0d expected 3 and 4",
               first_rsp_cyc, second_setup_cyc);
    end
    checks++;
    if (second_paddr !== 16'h0020) begin
      failures++;
      $display("[TB] FAIL b2b_second_addr: got %h expected 0020", second_paddr);
    end
  endtask

  task automatic test_random();
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdval;
    int waits;
    for (int i = 0; i < 16; i++) begin
      wr    = 1'($urandom);
      addr  = AW'($urandom);
      wdata = DW'($urandom);
      rdval = DW'($urandom);
      waits = $urandom_range(0, TO + 1);
      do_txn(wr, addr, wdata, waits, rdval, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0030;
    bus.pready    = 1'b0;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if (bus.penable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_pre: got penable=%b expected 1", bus.penable);
    end
    @(posedge pclk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_async: got psel=%b penable=%b rsp_valid=%b expected 0 0 0",
               bus.psel, bus.penable, bus.rsp_valid);
    end
    repeat (2) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_after: got rsp_valid=%b cmd_ready=%b psel=%b expected 0 1 0",
               bus.rsp_valid, bus.cmd_ready, bus.psel);
    end
    do_txn(1'b0, 16'h0040, 32'h0, 1, 32'h0F0F_1234, "read_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_timeout();
    test_limit_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
APB requester that drives the configuration-register bus as the initiator. Those APB register slaves sit on this bus.
Accepts single read/write commands over a valid/ready interface and sequences APB SETUP/ACCESS phases. Waits for pready and returns read data or a timeout error on a one-cycle response strobe.
Sits between the system controller and the bank of APB configuration registers, one master per bus.

Parameters:
ADDRESS_BUS_WIDTH, 16, width of paddr and cmd_addr
DATA_BUS_WIDTH, 32, width of pwdata, prdata, cmd_wdata, rsp_rdata
TIMEOUT_CYCLES, 255, max ACCESS cycles without pready before abort (1..2^TIMEOUT_WIDTH-1)
TIMEOUT_WIDTH, 8, width of the wait counter

Ports:
pclk  in  1  bus clock; all logic on rising edge
reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDRESS_BUS_WIDTH  target address
cmd_wdata  in  DATA_BUS_WIDTH  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_BUS_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  timeout flag, qualified by rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDRESS_BUS_WIDTH  APB address
pwdata  out  DATA_BUS_WIDTH  APB write data
pready  in  1  APB ready; only a clean 1'b1 counts as ready (a released/'z' line is not-ready)
prdata  in  DATA_BUS_WIDTH  APB read data

Behaviour:
- Reset (async, reset==0) forces these values:
  - state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - cmd_ready=1 after reset deasserts.
- States are IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On a rising edge with cmd_valid=1: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, then go to SETUP.
- SETUP (exactly one cycle): psel=1, penable=0, cmd_ready=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1.
  - paddr, pwrite and pwdata stay stable throughout; cmd_* changes are ignored.
- Completion: on a rising edge in ACCESS with pready==1:
  - For reads, capture prdata into rsp_rdata.
  - For writes, set rsp_rdata=0.
  - Set rsp_err=0 and pulse rsp_valid=1 for one cycle.
  - Drop psel/penable and return to IDLE; cmd_ready=1 in the same cycle as rsp_valid.
- Latency:
  - Zero wait states: accept edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid high in N+3.
  - Each wait state adds one cycle.
- Timeout:
  - The wait counter clears on entering ACCESS and increments on each ACCESS edge with pready!=1.
  - When the count reaches TIMEOUT_CYCLES and pready is still !=1, abort: rsp_valid=1, rsp_err=1, rsp_rdata=0, psel/penable=0, go to IDLE.
  - pready==1 on the same edge as the limit counts as success (success wins).
- Back-to-back commands: the next command can be accepted on the edge where rsp_valid is high. A new SETUP follows one cycle later, with no idle gap beyond IDLE.
- cmd_valid is ignored outside IDLE; there is no command queueing.
- paddr/pwdata/pwrite hold their last values in IDLE. prdata is ignored except on a read completion edge.
- Reset mid-transfer: psel/penable drop immediately (async) and no rsp_valid is generated.
- The counter saturates and never wraps.

Decomposition:
- Shared package apb_cfg_pkg:
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - default bus widths
  - default TIMEOUT_CYCLES
- Sub-module apb_wait_timer: saturating counter with clear/enable inputs and an expired output, width TIMEOUT_WIDTH.
- FSM, bus registers and response logic stay in apb_cfg_master.

Test Plan:
- Write 0x0000_0003 to 0x0004, slave ready immediately -> psel rises N+1, penable N+2, paddr=0x0004 and pwdata=0x3 stable, rsp_valid=1 with rsp_err=0 and rsp_rdata=0 at N+3.
- Read 0x0008, slave ready after 2 wait states returning 0xDEAD_BEEF -> penable held 3 cycles, rsp_valid at N+5, rsp_rdata=0xDEAD_BEEF.
- TIMEOUT_CYCLES=16, pready stuck at 0 (or 'z) -> abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0, psel=0, cmd_ready=1.
- cmd_valid held high while cmd_addr toggles 0x0010/0x0020 during a transfer -> paddr stays 0x0010; the next command is accepted on the rsp_valid edge, giving exactly two transfers.
- pready=1 on the exact edge the counter hits the limit -> rsp_err=0, data captured.
- Reset asserted during ACCESS -> psel/penable/rsp_valid go to 0 without waiting for a clock edge. After release, cmd_ready=1 and a fresh read completes normally.
